lsu_mmio_ctrl: RTL
==================

LSU_MMIO_CTRL -- requirements
Module: lsu_mmio_ctrl

Interface
REQ-001 SHALL have parameter NUM_MMIO, default 2, giving the number of MMIO slave windows (1..8).
REQ-002 SHALL have parameter DMEM_LIMIT, default 32'h100; addresses below it are data memory.
REQ-003 SHALL have parameters MMIO_BASE, default 32'h100, and MMIO_STRIDE, default 32'h100 (power of two), giving window i = [BASE+i*STRIDE, BASE+(i+1)*STRIDE).
REQ-004 SHALL have parameter TIMEOUT, default 15, giving the maximum number of BUSY cycles without an ack.
REQ-005 SHALL have one clock; reset is asynchronous and active-low: i_clk in 1, rising-edge clock; i_rstn in 1, asynchronous active-low reset.
REQ-006 SHALL have the pipeline side ports: i_valid in 1; i_re in 1; i_we in 1; i_addr in 32; i_wdata in 32; i_size in 2 (rv_pkg BYTE/HWORD/WORD); i_sign_ext in 1.
REQ-007 SHALL have the pipeline side ports: o_stall out 1; o_done out 1 (one-cycle pulse); o_rdata out 32; o_fault out 1; o_fault_cause out 2.
REQ-008 SHALL have the data-memory ports: o_dmem_req out 1; o_dmem_we out 1; o_dmem_addr out 32 (word aligned); o_dmem_wdata out 32; o_dmem_be out 4; i_dmem_ack in 1; i_dmem_rdata in 32.
REQ-009 SHALL have the MMIO ports: o_mmio_sel out NUM_MMIO (one-hot); o_mmio_we out 1; o_mmio_re out 1; o_mmio_offs out log2(STRIDE); o_mmio_wdata out 32; o_mmio_be out 4; i_mmio_ack in NUM_MMIO; i_mmio_rdata in 32*NUM_MMIO, where slave i uses bits [32i+31:32i].

Function
REQ-010 SHALL treat a request as present when i_valid and (i_re or i_we); when both i_re and i_we are set, the request SHALL be a write.
REQ-011 SHALL decode the target in IDLE: dmem if i_addr < DMEM_LIMIT; MMIO i if i_addr falls in window i; otherwise unmapped.
REQ-012 SHALL flag a misaligned request when: HWORD with addr[0]=1; WORD with addr[1:0]!=0; or i_size=2'b11.
REQ-013 SHALL use FSM states IDLE, BUSY and RESP.
REQ-014 SHALL transition IDLE->BUSY on a legal request, latching addr, data, size, sign_ext, direction and target.
REQ-015 SHALL transition IDLE->RESP on an illegal request, with no target access and the fault recorded.
REQ-016 SHALL transition BUSY->RESP on the selected target's ack, or on timeout.
REQ-017 SHALL transition RESP->IDLE unconditionally.
REQ-018 SHALL give misaligned fault priority over unmapped fault; o_fault_cause encodes 01 misaligned, 10 unmapped, 11 timeout, 00 none.
REQ-019 SHALL drive target request outputs from registers, asserted throughout BUSY and low in all other states; o_dmem_addr = {addr[31:2],2'b00}.
REQ-020 SHALL generate byte enables: BYTE = 4'b0001<<addr[1:0]; HWORD = 4'b0011<<addr[1:0]; WORD = 4'hF.
REQ-021 SHALL replicate write data: BYTE as 4x wdata[7:0]; HWORD as 2x wdata[15:0]; WORD unchanged.
REQ-022 SHALL extract read data by shifting right by 8*addr[1:0], then zero- or sign-extending per the latched size and sign_ext.
REQ-023 SHALL register o_rdata on the ack cycle; o_rdata is valid while o_done=1 and 0 on faults and writes.
REQ-024 SHALL assert o_stall combinationally: (IDLE and request present) or BUSY; o_stall SHALL be low in RESP.
REQ-025 SHALL assert o_done, o_fault and o_fault_cause in RESP only.
REQ-026 SHALL time latency from request cycle 0: ack sampled in cycle k gives o_done in cycle k+1; minimum latency is 2 cycles (ack in cycle 1).
REQ-027 SHALL clear a 4-bit timeout counter on BUSY entry and increment it each BUSY cycle without an ack; reaching TIMEOUT SHALL drop the request and fault with cause 11.
REQ-028 SHALL let an ack in the same cycle as timeout win: no fault, data captured.
REQ-029 SHALL ignore acks from non-selected targets and any ack outside BUSY.
REQ-030 SHALL not sample new pipeline inputs while in BUSY or RESP.

Reset
REQ-031 SHALL, on i_rstn low, immediately set the state to IDLE and drive every output to 0 (o_stall reflects IDLE).
REQ-032 SHALL, on reset mid-BUSY, abandon the outstanding access, with no o_done and no fault after release.

Structure
REQ-033 SHALL declare lsu_state_t (IDLE/BUSY/RESP) and lsu_fault_t (NONE/MISALIGN/UNMAPPED/TIMEOUT) in rv_pkg, reusing the existing memory-size enum there.
REQ-034 SHALL place the byte-enable, write-replication and read-extract logic in a combinational sub-module lsu_lane_align, shared between the dmem and MMIO paths.

Verification
REQ-035 SHALL cover: LB sign_ext, addr 0x03, dmem word 0x80FF_1234, ack in cycle 1 -> be 4'b1000, o_done cycle 2, o_rdata 0xFFFF_FF80.
REQ-036 SHALL cover: SH addr 0x06, wdata 0x0000_ABCD -> o_dmem_be 4'b1100, o_dmem_wdata 0xABCD_ABCD, o_dmem_addr 0x04.
REQ-037 SHALL cover: LW addr 0x102 -> no request issued, o_done+o_fault in cycle 1, cause 01; LW addr 0x400 -> cause 10.
REQ-038 SHALL cover: SW addr 0x204 to MMIO slave 1 with ack withheld -> o_mmio_sel 2'b10, o_mmio_offs 0x04, cause 11 after 15 BUSY cycles; ack on cycle 15 -> no fault.
REQ-039 SHALL cover: i_rstn pulsed low mid-BUSY -> all outputs 0 asynchronously, FSM in IDLE, no o_done after release.
REQ-040 SHALL cover: i_re and i_we both set -> write performed, o_rdata 0.

Source files
------------

// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared types for the load/store unit: memory access size,
//               LSU FSM states and fault causes, plus an alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  // Memory access size as presented by the pipeline; 2'b11 is not a legal size
  typedef enum logic [1:0] {
    MEM_BYTE  = 2'b00,
    MEM_HWORD = 2'b01,
    MEM_WORD  = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } lsu_state_t;

  // Encoding matches the o_fault_cause output directly
  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_UNMAPPED = 2'b10,
    FAULT_TIMEOUT  = 2'b11
  } lsu_fault_t;

  // True when the access does not sit on its natural boundary or the size is illegal
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      MEM_BYTE:  mis = 1'b0;
      MEM_HWORD: mis = addr_lo[0];
      MEM_WORD:  mis = (addr_lo != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module      : lsu_lane_align
// Description : Byte-lane steering shared by the dmem and MMIO paths: byte
//               enables, write-data replication and read-data extraction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
  import rv_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  // Lane selection per access size; the addressed lane is moved to bit 0 for reads
  always_comb begin
    shifted   = rdata_raw >> {addr_lo, 3'b000};
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = shifted;
    case (size)
      MEM_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = sign_ext ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      end
      MEM_HWORD: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = sign_ext ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      end
      MEM_WORD: begin
        be        = 4'hF;
        wdata_rep = wdata;
        rdata_ext = shifted;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = shifted;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mmio_ctrl.sv
// ============================================================================
// Module      : lsu_mmio_ctrl
// Description : Load/store controller routing pipeline accesses to data
//               memory or one of NUM_MMIO MMIO windows, with alignment and
//               address-map faults and a bounded wait for the target ack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mmio_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned NUM_MMIO    = 2,
  parameter logic [31:0] DMEM_LIMIT  = 32'h100,
  parameter logic [31:0] MMIO_BASE   = 32'h100,
  parameter logic [31:0] MMIO_STRIDE = 32'h100,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  // pipeline side
  input  logic                          i_valid,
  input  logic                          i_re,
  input  logic                          i_we,
  input  logic [31:0]                   i_addr,
  input  logic [31:0]                   i_wdata,
  input  logic [1:0]                    i_size,
  input  logic                          i_sign_ext,
  output logic                          o_stall,
  output logic                          o_done,
  output logic [31:0]                   o_rdata,
  output logic                          o_fault,
  output logic [1:0]                    o_fault_cause,
  // data memory
  output logic                          o_dmem_req,
  output logic                          o_dmem_we,
  output logic [31:0]                   o_dmem_addr,
  output logic [31:0]                   o_dmem_wdata,
  output logic [3:0]                    o_dmem_be,
  input  logic                          i_dmem_ack,
  input  logic [31:0]                   i_dmem_rdata,
  // MMIO slaves
  output logic [NUM_MMIO-1:0]           o_mmio_sel,
  output logic                          o_mmio_we,
  output logic                          o_mmio_re,
  output logic [$clog2(MMIO_STRIDE)-1:0] o_mmio_offs,
  output logic [31:0]                   o_mmio_wdata,
  output logic [3:0]                    o_mmio_be,
  input  logic [NUM_MMIO-1:0]           i_mmio_ack,
  input  logic [32*NUM_MMIO-1:0]        i_mmio_rdata
);

  localparam int unsigned OFFS_W = $clog2(MMIO_STRIDE);

  lsu_state_t state, state_nxt;

  logic                req_present, req_write, req_legal, misalign;
  logic                hit_dmem, hit_mmio;
  logic [31:0]         mmio_diff, mmio_idx;
  logic [NUM_MMIO-1:0] mmio_hit_vec;

  logic        lat_write, lat_sign;
  logic [1:0]  lat_size, lat_addr_lo;
  logic [3:0]  tmo_cnt;
  logic        tgt_ack, timed_out;
  logic [31:0] raw_rdata;

  logic [1:0]  lane_size, lane_addr_lo;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  // Request qualification and address decode; dmem wins over any overlapping window
  always_comb begin
    req_present = i_valid & (i_re | i_we);
    req_write   = i_we;
    misalign    = is_misaligned(i_size, i_addr[1:0]);
    hit_dmem    = (i_addr < DMEM_LIMIT);
    mmio_diff   = i_addr - MMIO_BASE;
    mmio_idx    = mmio_diff >> OFFS_W;
    hit_mmio    = !hit_dmem && (i_addr >= MMIO_BASE) && (mmio_idx < NUM_MMIO);
    for (int unsigned i = 0; i < NUM_MMIO; i++) begin
      mmio_hit_vec[i] = hit_mmio && (mmio_idx == i);
    end
    req_legal   = !misalign && (hit_dmem || hit_mmio);
  end

  // Ack and read data from the selected target only; request outputs are low outside BUSY
  always_comb begin
    tgt_ack   = (o_dmem_req & i_dmem_ack) | (|(i_mmio_ack & o_mmio_sel));
    timed_out = (state == BUSY) && !tgt_ack && (tmo_cnt == 4'(TIMEOUT - 1));
    raw_rdata = o_dmem_req ? i_dmem_rdata : 32'b0;
    for (int unsigned i = 0; i < NUM_MMIO; i++) begin
      if (o_mmio_sel[i]) raw_rdata = raw_rdata | i_mmio_rdata[32*i +: 32];
    end
    // IDLE steers the incoming write; BUSY steers the returning read
    lane_size    = (state == IDLE) ? i_size       : lat_size;
    lane_addr_lo = (state == IDLE) ? i_addr[1:0]  : lat_addr_lo;
  end

  lsu_lane_align u_lane_align (
    .size      (lane_size),
    .addr_lo   (lane_addr_lo),
    .sign_ext  (lat_sign),
    .wdata     (i_wdata),
    .rdata_raw (raw_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next state and stall
  always_comb begin
    state_nxt = state;
    o_stall   = 1'b0;
    case (state)
      IDLE: begin
        o_stall = req_present;
        if (req_present) state_nxt = req_legal ? BUSY : RESP;
      end
      BUSY: begin
        o_stall = 1'b1;
        if (tgt_ack || timed_out) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Target request registers: loaded on BUSY entry, cleared whenever BUSY is left
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_be    <= '0;
      o_mmio_sel   <= '0;
      o_mmio_we    <= 1'b0;
      o_mmio_re    <= 1'b0;
      o_mmio_offs  <= '0;
      o_mmio_wdata <= '0;
      o_mmio_be    <= '0;
      lat_write    <= 1'b0;
      lat_sign     <= 1'b0;
      lat_size     <= '0;
      lat_addr_lo  <= '0;
      tmo_cnt      <= '0;
    end else if (state == IDLE && state_nxt == BUSY) begin
      o_dmem_req   <= hit_dmem;
      o_dmem_we    <= hit_dmem & req_write;
      o_dmem_addr  <= hit_dmem ? {i_addr[31:2], 2'b00} : 32'b0;
      o_dmem_wdata <= (hit_dmem & req_write) ? lane_wdata : 32'b0;
      o_dmem_be    <= hit_dmem ? lane_be : 4'b0;
      o_mmio_sel   <= mmio_hit_vec;
      o_mmio_we    <= hit_mmio & req_write;
      o_mmio_re    <= hit_mmio & !req_write;
      o_mmio_offs  <= hit_mmio ? mmio_diff[OFFS_W-1:0] : '0;
      o_mmio_wdata <= (hit_mmio & req_write) ? lane_wdata : 32'b0;
      o_mmio_be    <= hit_mmio ? lane_be : 4'b0;
      lat_write    <= req_write;
      lat_sign     <= i_sign_ext;
      lat_size     <= i_size;
      lat_addr_lo  <= i_addr[1:0];
      tmo_cnt      <= '0;
    end else if (state_nxt != BUSY) begin
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_be    <= '0;
      o_mmio_sel   <= '0;
      o_mmio_we    <= 1'b0;
      o_mmio_re    <= 1'b0;
      o_mmio_offs  <= '0;
      o_mmio_wdata <= '0;
      o_mmio_be    <= '0;
    end else if (!tgt_ack) begin
      tmo_cnt      <= tmo_cnt + 4'd1;
    end
  end

  // Response registers: populated on RESP entry so they are visible in RESP only
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_done        <= 1'b0;
      o_fault       <= 1'b0;
      o_fault_cause <= FAULT_NONE;
      o_rdata       <= '0;
    end else if (state == IDLE && state_nxt == RESP) begin
      o_done        <= 1'b1;
      o_fault       <= 1'b1;
      o_fault_cause <= misalign ? FAULT_MISALIGN : FAULT_UNMAPPED;
      o_rdata       <= '0;
    end else if (state == BUSY && state_nxt == RESP) begin
      o_done <= 1'b1;
      if (tgt_ack) begin
        // an ack arriving on the timeout cycle still completes normally
        o_fault       <= 1'b0;
        o_fault_cause <= FAULT_NONE;
        o_rdata       <= lat_write ? 32'b0 : lane_rdata;
      end else begin
        o_fault       <= 1'b1;
        o_fault_cause <= FAULT_TIMEOUT;
        o_rdata       <= '0;
      end
    end else begin
      o_done        <= 1'b0;
      o_fault       <= 1'b0;
      o_fault_cause <= FAULT_NONE;
      o_rdata       <= '0;
    end
  end

endmodule

`default_nettype wire
